// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with glitch filter, frame checker, optional E0/F0 prefix
// folding and a show-ahead scan-code FIFO. Single clock domain.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000,
  parameter int DECODE_MODE = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic                          out_ext,
  output logic                          out_break,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // PS/2 uses odd parity: data plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [8:0] v);
    return ^v;
  endfunction

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic          filt_clk_r, filt_d_r;
  logic [FW-1:0] filt_cnt_r;
  logic          sample_s, timeout_s;
  logic [1:0]    state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          par_r;
  logic [TW-1:0] to_cnt_r;
  logic          good_r;
  logic [7:0]    byte_r;
  logic          perr_r, ferr_r;
  logic          ext_pend_r, brk_pend_r;
  logic          push_s;
  logic [9:0]    push_word_s;
  logic [9:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [LW-1:0] level_r, level_next_s;
  logic          full_s, pop_s, wr_s, ovf_s;
  logic          out_valid_r, overflow_r;
  logic [9:0]    head_r, head_next_s;

  // Two-flop synchronisers for both PS/2 lines (idle-high)
  always_ff @(posedge clk) begin
    if (resetn) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: accept a new clock level only after FILTER_LEN differing cycles
  always_ff @(posedge clk) begin
    if (resetn) begin
      filt_clk_r <= 1'b1;
      filt_d_r   <= 1'b1;
      filt_cnt_r <= {FW{1'b0}};
    end else begin
      filt_d_r <= filt_clk_r;
      if (clk_sync_r != filt_clk_r) begin
        if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
          filt_clk_r <= clk_sync_r;
          filt_cnt_r <= {FW{1'b0}};
        end else begin
          filt_cnt_r <= filt_cnt_r + FW'(1);
        end
      end else begin
        filt_cnt_r <= {FW{1'b0}};
      end
    end
  end

  assign sample_s  = filt_d_r & ~filt_clk_r;
  assign timeout_s = (state_r != ST_IDLE) && !sample_s &&
                     (to_cnt_r == TW'(TIMEOUT_CYC - 1));

  // Frame receiver: start/data/parity/stop, judged at the stop bit
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_r     <= 1'b0;
      to_cnt_r  <= {TW{1'b0}};
      good_r    <= 1'b0;
      byte_r    <= 8'h00;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      good_r <= 1'b0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      if (timeout_s) begin
        state_r  <= ST_IDLE;
        ferr_r   <= 1'b1;
        to_cnt_r <= {TW{1'b0}};
      end else begin
        if ((state_r == ST_IDLE) || sample_s) begin
          to_cnt_r <= {TW{1'b0}};
        end else begin
          to_cnt_r <= to_cnt_r + TW'(1);
        end
        if (sample_s) begin
          case (state_r)
            ST_IDLE: begin
              if (!data_sync_r) begin
                state_r   <= ST_DATA;
                bit_cnt_r <= 3'd0;
              end else begin
                state_r <= ST_IDLE;
              end
            end
            ST_DATA: begin
              shift_r <= {data_sync_r, shift_r[7:1]};
              if (bit_cnt_r == 3'd7) begin
                state_r <= ST_PARITY;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
            ST_PARITY: begin
              par_r   <= data_sync_r;
              state_r <= ST_STOP;
            end
            ST_STOP: begin
              state_r <= ST_IDLE;
              if (!data_sync_r) begin
                ferr_r <= 1'b1;
              end else if (!odd_parity_ok({par_r, shift_r})) begin
                perr_r <= 1'b1;
              end else begin
                good_r <= 1'b1;
                byte_r <= shift_r;
              end
            end
            default: state_r <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Decide whether a good byte is pushed and with which prefix flags
  always_comb begin
    push_s      = 1'b0;
    push_word_s = {ext_pend_r, brk_pend_r, byte_r};
    if (good_r) begin
      if (DECODE_MODE == 0) begin
        push_s      = 1'b1;
        push_word_s = {2'b00, byte_r};
      end else if ((byte_r == 8'hE0) || (byte_r == 8'hF0)) begin
        push_s = 1'b0;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Prefix flags: set by E0/F0, consumed by the next pushed byte, dropped on error
  always_ff @(posedge clk) begin
    if (resetn) begin
      ext_pend_r <= 1'b0;
      brk_pend_r <= 1'b0;
    end else if (perr_r || ferr_r) begin
      ext_pend_r <= 1'b0;
      brk_pend_r <= 1'b0;
    end else if (good_r && (DECODE_MODE != 0)) begin
      if (byte_r == 8'hE0) begin
        ext_pend_r <= 1'b1;
      end else if (byte_r == 8'hF0) begin
        brk_pend_r <= 1'b1;
      end else begin
        ext_pend_r <= 1'b0;
        brk_pend_r <= 1'b0;
      end
    end
  end

  assign full_s = (level_r == LW'(FIFO_DEPTH));
  assign pop_s  = out_valid_r & out_ready;
  assign wr_s   = push_s & (~full_s | pop_s);
  assign ovf_s  = push_s & full_s & ~pop_s;

  // Next occupancy, read pointer and head entry (head forwarded when written into the new head slot)
  always_comb begin
    case ({wr_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
    if (pop_s) begin
      rd_next_s = rd_ptr_r + AW'(1);
    end else begin
      rd_next_s = rd_ptr_r;
    end
    if (wr_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = push_word_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  // FIFO pointers, occupancy, registered head and sticky overflow
  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {LW{1'b0}};
      out_valid_r <= 1'b0;
      head_r      <= 10'h000;
      overflow_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r    <= rd_next_s;
      level_r     <= level_next_s;
      out_valid_r <= (level_next_s != {LW{1'b0}});
      head_r      <= head_next_s;
      if (ovf_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = head_r[7:0];
  assign out_ext    = head_r[9];
  assign out_break  = head_r[8];
  assign level      = level_r;
  assign overflow   = overflow_r;
  assign parity_err = perr_r;
  assign frame_err  = ferr_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench: dut_a is raw mode with a 4-deep FIFO, dut_b folds E0/F0
// prefixes with an 8-deep FIFO. Both share the PS/2 lines and reset.
module tb_ps2_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, ps2_clk, ps2_data, ready_a, ready_b;
  logic       valid_a, ext_a, brk_a, ovf_a, perr_a, ferr_a;
  logic [7:0] data_a;
  logic [2:0] level_a;
  logic       valid_b, ext_b, brk_b, ovf_b, perr_b, ferr_b;
  logic [7:0] data_b;
  logic [3:0] level_b;

  int vectors = 0;
  int miscompares = 0;
  int perr_cnt_a = 0, ferr_cnt_a = 0, perr_cnt_b = 0, ferr_cnt_b = 0;
  int p0, f0, pb0, fb0;
  logic [7:0] exp_q [4];

  ps2_rx_fifo #(.FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYC(200), .DECODE_MODE(0)) dut_a (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_ext(ext_a),
    .out_break(brk_a), .level(level_a), .overflow(ovf_a), .parity_err(perr_a),
    .frame_err(ferr_a));

  ps2_rx_fifo #(.FIFO_DEPTH(8), .FILTER_LEN(4), .TIMEOUT_CYC(200), .DECODE_MODE(1)) dut_b (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_ext(ext_b),
    .out_break(brk_b), .level(level_b), .overflow(ovf_b), .parity_err(perr_b),
    .frame_err(ferr_b));

  // Count error pulses so single-pulse behaviour can be checked
  always @(posedge clk) begin
    if (perr_a) perr_cnt_a <= perr_cnt_a + 1;
    if (ferr_a) ferr_cnt_a <= ferr_cnt_a + 1;
    if (perr_b) perr_cnt_b <= perr_cnt_b + 1;
    if (ferr_b) ferr_cnt_b <= ferr_cnt_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(10);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain; 1: check push latency on dut_a; 2: pop dut_a in the push cycle
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop, input int mode);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ par_flip);
    @(negedge clk) ps2_data = stop;
    cyc(10);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      cyc(7);
      chk("latency_not_yet", valid_a, 1'b0);
      cyc(1);
      chk("latency_valid", valid_a, 1'b1);
      cyc(2);
    end else if (mode == 2) begin
      cyc(7);
      ready_a = 1'b1;
      cyc(1);
      ready_a = 1'b0;
      cyc(2);
    end else begin
      cyc(10);
    end
    ps2_clk = 1'b1;
    cyc(10);
  endtask

  task automatic send_partial(input int n);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic pulse_reset();
    resetn = 1'b1;
    cyc(2);
    resetn = 1'b0;
    cyc(2);
  endtask

  task automatic pop_a();
    ready_a = 1'b1;
    cyc(1);
    ready_a = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    cyc(3);
    chk("rst_level_a", level_a, 3'd0);
    chk("rst_valid_a", valid_a, 1'b0);
    chk("rst_ovf_a", ovf_a, 1'b0);
    chk("rst_perr_a", perr_a, 1'b0);
    chk("rst_ferr_a", ferr_a, 1'b0);
    chk("rst_level_b", level_b, 4'd0);
    resetn = 1'b0;
    cyc(5);

    // Short low glitch on ps2_clk must be ignored
    p0 = perr_cnt_a; f0 = ferr_cnt_a;
    ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(20);
    chk("glitch_level", level_a, 3'd0);
    chk("glitch_ferr", ferr_cnt_a - f0, 0);
    chk("glitch_perr", perr_cnt_a - p0, 0);

    // Basic good frame, push latency, then pop
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    chk("f1c_valid", valid_a, 1'b1);
    chk("f1c_data", data_a, 8'h1C);
    chk("f1c_level", level_a, 3'd1);
    chk("f1c_ext", ext_a, 1'b0);
    chk("f1c_brk", brk_a, 1'b0);
    chk("f1c_data_b", data_b, 8'h1C);
    ready_a = 1'b1; ready_b = 1'b1; cyc(1); ready_a = 1'b0; ready_b = 1'b0;
    chk("pop_level_a", level_a, 3'd0);
    chk("pop_valid_a", valid_a, 1'b0);
    chk("pop_level_b", level_b, 4'd0);
    ready_a = 1'b1; cyc(3); ready_a = 1'b0;
    chk("empty_pop_level", level_a, 3'd0);

    // Prefix folding E0 F0 75
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    send_frame(8'h75, 1'b0, 1'b1, 0);
    chk("fold_level_b", level_b, 4'd1);
    chk("fold_data_b", data_b, 8'h75);
    chk("fold_ext_b", ext_b, 1'b1);
    chk("fold_brk_b", brk_b, 1'b1);
    chk("raw_level_a", level_a, 3'd3);
    chk("raw_head_a", data_a, 8'hE0);
    chk("raw_ext_a", ext_a, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 0);
    chk("fold2_level_b", level_b, 4'd2);
    ready_b = 1'b1; cyc(1); ready_b = 1'b0;
    chk("pend_clr_data", data_b, 8'h29);
    chk("pend_clr_ext", ext_b, 1'b0);
    chk("pend_clr_brk", brk_b, 1'b0);
    pulse_reset();
    chk("rst2_level_a", level_a, 3'd0);
    chk("rst2_valid_a", valid_a, 1'b0);
    chk("rst2_level_b", level_b, 4'd0);

    // Parity and stop errors
    p0 = perr_cnt_a; pb0 = perr_cnt_b;
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    chk("perr_once_a", perr_cnt_a - p0, 1);
    chk("perr_once_b", perr_cnt_b - pb0, 1);
    chk("perr_level_a", level_a, 3'd0);
    f0 = ferr_cnt_a; fb0 = ferr_cnt_b;
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    chk("ferr_once_a", ferr_cnt_a - f0, 1);
    chk("ferr_once_b", ferr_cnt_b - fb0, 1);
    chk("ferr_level_a", level_a, 3'd0);
    chk("ferr_level_b", level_b, 4'd0);

    // An error between prefix and byte drops the prefix
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    send_frame(8'h75, 1'b0, 1'b1, 0);
    chk("errclr_level_b", level_b, 4'd1);
    chk("errclr_data_b", data_b, 8'h75);
    chk("errclr_ext_b", ext_b, 1'b0);
    chk("errclr_level_a", level_a, 3'd2);
    pulse_reset();

    // Timeout of a partial frame, then recovery
    f0 = ferr_cnt_a; fb0 = ferr_cnt_b;
    send_partial(3);
    cyc(250);
    chk("tmo_ferr_a", ferr_cnt_a - f0, 1);
    chk("tmo_ferr_b", ferr_cnt_b - fb0, 1);
    send_frame(8'h29, 1'b0, 1'b1, 0);
    chk("tmo_rec_level", level_a, 3'd1);
    chk("tmo_rec_data", data_a, 8'h29);
    chk("tmo_rec_data_b", data_b, 8'h29);
    pulse_reset();

    // Reset mid-frame: no error pulse, next frame received
    send_partial(3);
    f0 = ferr_cnt_a;
    pulse_reset();
    cyc(250);
    chk("midrst_ferr", ferr_cnt_a - f0, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    chk("midrst_level", level_a, 3'd1);
    chk("midrst_data", data_a, 8'h5A);
    pulse_reset();

    // Overflow: five frames into a 4-deep FIFO
    send_frame(8'h11, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0);
    send_frame(8'h33, 1'b0, 1'b1, 0);
    send_frame(8'h44, 1'b0, 1'b1, 0);
    chk("prefull_ovf", ovf_a, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 0);
    chk("ovf_level", level_a, 3'd4);
    chk("ovf_flag", ovf_a, 1'b1);
    chk("ovf_level_b", level_b, 4'd5);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", data_a, exp_q[i]);
      pop_a();
    end
    chk("ovf_drain_level", level_a, 3'd0);
    chk("ovf_sticky", ovf_a, 1'b1);
    pulse_reset();
    chk("rst_ovf_clear", ovf_a, 1'b0);

    // Full FIFO with push and pop in the same cycle
    send_frame(8'hA1, 1'b0, 1'b1, 0);
    send_frame(8'hA2, 1'b0, 1'b1, 0);
    send_frame(8'hA3, 1'b0, 1'b1, 0);
    send_frame(8'hA4, 1'b0, 1'b1, 0);
    chk("full_level", level_a, 3'd4);
    send_frame(8'hA5, 1'b0, 1'b1, 2);
    chk("pp_level", level_a, 3'd4);
    chk("pp_ovf", ovf_a, 1'b0);
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", data_a, exp_q[i]);
      pop_a();
    end
    chk("pp_drain_level", level_a, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
